// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared constants and helpers for the multi-port register file
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

   localparam int RF_DW        = 32;
   localparam int RF_DEPTH     = 32;
   localparam int RF_AW        = 5;
   // popcount operand width; callers zero-extend their vector into it
   localparam int RF_MAX_DEPTH = 1024;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   function automatic int popcount(input logic [RF_MAX_DEPTH-1:0] vec);
      int count;
      count = 0;
      for (int k = 0; k < RF_MAX_DEPTH; k++) begin
         if (vec[k]) count = count + 1;
      end
      return count;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard : per-register pending-write bits, busy count, error flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH = RF_DEPTH,
   parameter int AW    = RF_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] wr_mask,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   output logic [DEPTH-1:0] busy,
   output logic [AW:0]      busy_cnt,
   output logic             sb_err
);

   localparam int CW = AW + 1;

   logic [DEPTH-1:0]        busy_d, busy_q;
   logic [DEPTH-1:0]        iss_mask;
   logic [DEPTH-1:0]        err_mask;
   logic [RF_MAX_DEPTH-1:0] busy_ext;
   logic [AW:0]             busy_cnt_d, busy_cnt_q;
   logic                    sb_err_d, sb_err_q;

   always_comb begin
      iss_mask = '0;
      if (iss_en && (iss_addr != '0)) iss_mask[iss_addr] = 1'b1;

      // issue is applied after the clear so a new producer supersedes the retiring one
      busy_d    = (busy_q & ~wr_mask) | iss_mask;
      busy_d[0] = 1'b0;

      err_mask    = wr_mask & ~busy_q & ~iss_mask;
      err_mask[0] = 1'b0;
      sb_err_d    = sb_err_q | (|err_mask);

      if (rst) begin
         busy_d   = '0;
         sb_err_d = 1'b0;
      end

      busy_ext               = '0;
      busy_ext[DEPTH-1:0]    = busy_d;
      busy_cnt_d             = CW'(popcount(busy_ext));
   end

   always_ff @(posedge clk) begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      sb_err_q   <= sb_err_d;
   end

   assign busy     = busy_q;
   assign busy_cnt = busy_cnt_q;
   assign sb_err   = sb_err_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : NR-read / NW-write register file with bypass and RAW scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DW     = RF_DW,
   parameter int DEPTH  = RF_DEPTH,
   parameter int AW     = RF_AW,
   parameter int NR     = 2,
   parameter int NW     = 2,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NR*AW-1:0] rd_addr,
   output logic [NR*DW-1:0] rd_data,
   output logic [NR-1:0]    rd_busy,
   input  logic [NW-1:0]    wr_en,
   input  logic [NW*AW-1:0] wr_addr,
   input  logic [NW*DW-1:0] wr_data,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   output logic [AW:0]      busy_cnt,
   output logic             sb_err
);

   if (clog2(DEPTH) != AW) begin : g_aw_check
      $error("regfile_mp: AW must equal log2(DEPTH)");
   end

   logic [DW-1:0]    regs_d [DEPTH];
   logic [DW-1:0]    regs_q [DEPTH];
   logic [DEPTH-1:0] wr_mask;
   logic [DEPTH-1:0] busy;

   // ascending port order lets the highest-indexed writer overwrite the others
   always_comb begin
      regs_d  = regs_q;
      wr_mask = '0;
      for (int j = 0; j < NW; j++) begin
         if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
            regs_d[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
            wr_mask[wr_addr[j*AW +: AW]] = 1'b1;
         end
      end
      if (rst) begin
         wr_mask = '0;
         for (int k = 0; k < DEPTH; k++) regs_d[k] = '0;
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   regfile_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .wr_mask  (wr_mask),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy     (busy),
      .busy_cnt (busy_cnt),
      .sb_err   (sb_err)
   );

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          pend;

      always_comb begin
         addr = rd_addr[i*AW +: AW];
         data = regs_q[addr];
         pend = busy[addr];
         if ((BYPASS != 0) && !rst) begin
            for (int j = 0; j < NW; j++) begin
               if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
                  data = wr_data[j*DW +: DW];
                  pend = 1'b0;
               end
            end
         end
         if (addr == '0) begin
            data = '0;
            pend = 1'b0;
         end
      end

      assign rd_data[i*DW +: DW] = data;
      assign rd_busy[i]          = pend;
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp : directed checks of regfile_mp with and without bypass
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic [5:0]  busy_cnt, busy_cnt_nb;
   logic        sb_err, sb_err_nb;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NR(2), .NW(2), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
      .iss_addr(iss_addr), .busy_cnt(busy_cnt), .sb_err(sb_err)
   );

   regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NR(2), .NW(2), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
      .iss_addr(iss_addr), .busy_cnt(busy_cnt_nb), .sb_err(sb_err_nb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst    = 1'b0;
      wr_en  = 2'b00;
      iss_en = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
      do_reset();
      for (int a = 0; a < 32; a++) begin
         rd_addr = {a[4:0], a[4:0]};
         #1;
         n_tests++;
         if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_read addr=%0d got data=%h busy=%b want data=0 busy=00", a, rd_data, rd_busy);
         end
      end
      n_tests++;
      if (busy_cnt !== 6'd0 || sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state got cnt=%0d err=%b want cnt=0 err=0", busy_cnt, sb_err);
      end
      rd_addr = '0;
      wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hDEADBEEF;
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL r0_bypass got %h want 00000000", rd_data[31:0]);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL r0_write got data=%h busy=%b cnt=%0d err=%b want 0/0/0/0",
                  rd_data[31:0], rd_busy[0], busy_cnt, sb_err);
      end
   endtask

   task automatic test_bypass();
      rd_addr[9:5] = 5'd5;
      wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'h12345678;
      #1;
      n_tests++;
      if (rd_data[63:32] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL bypass_same_cycle got %h want 12345678", rd_data[63:32]);
      end
      n_tests++;
      if (rd_data_nb[63:32] !== 32'h0) begin
         n_fail++;
         $display("FAIL nobypass_same_cycle got %h want 00000000", rd_data_nb[63:32]);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rd_data[63:32] !== 32'h12345678 || rd_data_nb[63:32] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL bypass_next_cycle got %h/%h want 12345678", rd_data[63:32], rd_data_nb[63:32]);
      end
      n_tests++;
      if (sb_err !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_sb_err got %b want 1", sb_err);
      end
   endtask

   task automatic test_conflict();
      rd_addr = {5'd7, 5'd7};
      wr_en = 2'b11;
      wr_addr = {5'd7, 5'd7};
      wr_data = {32'h22, 32'h11};
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'h22) begin
         n_fail++;
         $display("FAIL conflict_bypass got %h want 00000022", rd_data[31:0]);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'h22 || rd_data_nb[31:0] !== 32'h22) begin
         n_fail++;
         $display("FAIL conflict_array got %h/%h want 00000022", rd_data[31:0], rd_data_nb[31:0]);
      end
      n_tests++;
      if (sb_err !== 1'b1) begin
         n_fail++;
         $display("FAIL conflict_sb_err got %b want 1", sb_err);
      end
   endtask

   task automatic test_lifecycle();
      do_reset();
      iss_en = 1'b1; iss_addr = 5'd9;
      tick();
      idle();
      rd_addr[4:0] = 5'd9;
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
         n_fail++;
         $display("FAIL issue_r9 got busy=%b cnt=%0d want 1/1", rd_busy[0], busy_cnt);
      end
      wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'h99;
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h99 || rd_busy_nb[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL writeback_r9_bypass got busy=%b data=%h nb_busy=%b want 0/99/1",
                  rd_busy[0], rd_data[31:0], rd_busy_nb[0]);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL writeback_r9_after got busy=%b cnt=%0d err=%b want 0/0/0", rd_busy[0], busy_cnt, sb_err);
      end
   endtask

   task automatic test_issue_and_write();
      iss_en = 1'b1; iss_addr = 5'd3;
      tick();
      idle();
      rd_addr[4:0] = 5'd3;
      iss_en = 1'b1; iss_addr = 5'd3;
      wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h33;
      #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd1) begin
         n_fail++;
         $display("FAIL iss_wr_same_cycle got busy=%b cnt=%0d want 0/1", rd_busy[0], busy_cnt);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'h33 || rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1 || sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL iss_wr_after got data=%h busy=%b cnt=%0d err=%b want 33/1/1/0",
                  rd_data[31:0], rd_busy[0], busy_cnt, sb_err);
      end
      // issue together with a write to a non-busy register is not an error
      iss_en = 1'b1; iss_addr = 5'd6;
      wr_en = 2'b10; wr_addr[9:5] = 5'd6; wr_data[63:32] = 32'h66;
      tick();
      idle();
      #1;
      n_tests++;
      if (sb_err !== 1'b0 || busy_cnt !== 6'd2) begin
         n_fail++;
         $display("FAIL iss_wr_idle_reg got err=%b cnt=%0d want 0/2", sb_err, busy_cnt);
      end
      wr_en = 2'b01; wr_addr[4:0] = 5'd4; wr_data[31:0] = 32'h44;
      tick();
      idle();
      #1;
      n_tests++;
      if (sb_err !== 1'b1 || busy_cnt !== 6'd2) begin
         n_fail++;
         $display("FAIL sb_err_set got err=%b cnt=%0d want 1/2", sb_err, busy_cnt);
      end
      wr_addr = 'x; wr_data = 'x; iss_addr = 5'd0; iss_en = 1'b1;
      tick();
      tick();
      idle();
      #1;
      n_tests++;
      if (sb_err !== 1'b1 || busy_cnt !== 6'd2 || rd_data[31:0] !== 32'h33) begin
         n_fail++;
         $display("FAIL sb_err_sticky got err=%b cnt=%0d data=%h want 1/2/33", sb_err, busy_cnt, rd_data[31:0]);
      end
      wr_addr = '0; wr_data = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      iss_en = 1'b1; iss_addr = 5'd1;
      tick();
      idle();
      wr_en = 2'b01; wr_addr[4:0] = 5'd1; wr_data[31:0] = 32'hA5;
      tick();
      idle();
      for (int r = 1; r <= 4; r++) begin
         iss_en = 1'b1; iss_addr = r[4:0];
         tick();
      end
      idle();
      wr_en = 2'b10; wr_addr[9:5] = 5'd10; wr_data[63:32] = 32'h5;
      tick();
      idle();
      rd_addr = {5'd5, 5'd1};
      #1;
      n_tests++;
      if (busy_cnt !== 6'd4 || rd_data[31:0] !== 32'hA5 || rd_busy[0] !== 1'b1 || sb_err !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset got cnt=%0d data=%h busy=%b err=%b want 4/a5/1/1",
                  busy_cnt, rd_data[31:0], rd_busy[0], sb_err);
      end
      rst = 1'b1;
      wr_en = 2'b01; wr_addr[4:0] = 5'd1; wr_data[31:0] = 32'hFF;
      iss_en = 1'b1; iss_addr = 5'd5;
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'hA5) begin
         n_fail++;
         $display("FAIL reset_bypass_suppressed got %h want 000000a5", rd_data[31:0]);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rd_data[31:0] !== 32'h0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0 || sb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid got data=%h busy=%b cnt=%0d err=%b want 0/00/0/0",
                  rd_data[31:0], rd_busy, busy_cnt, sb_err);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_bypass();
      test_conflict();
      test_lifecycle();
      test_issue_and_write();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
